// File: rtl/bcd_pkg.sv
// Shared BCD types and single-digit step helpers for the score counter.
// Each helper returns {carry/borrow, digit}. The digit is always 0..9.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // One decimal digit +1. Carry out when the digit rolls 9 -> 0.
    function automatic logic [4:0] bcd_inc(input bcd_digit_t d);
        if (d >= BCD_MAX) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // One decimal digit -1. Borrow out when the digit rolls 0 -> 9.
    function automatic logic [4:0] bcd_dec(input bcd_digit_t d);
        if (d == 4'd0) begin
            return {1'b1, BCD_MAX};
        end
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted 0->1 transition. Releases give no pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a new level only after it has disagreed for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync;
                cnt   <= '0;
                press <= sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_score_counter.sv
// Two-digit BCD up/down score counter that feeds the seven-segment display.
// Inputs are debounced inc/dec/clr buttons and an optional auto-increment
// tick. Arithmetic is per decimal digit, so no value above 9 is ever stored.
module bcd_score_counter
    import bcd_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int DEB_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_clr,
    input  logic       run_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       update,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic          inc_press;
    logic          dec_press;
    logic          clr_press;
    logic [PW-1:0] presc;
    logic          tick;
    logic          inc_req;
    logic          dec_req;
    bcd_digit_t    tens_n;
    bcd_digit_t    ones_n;
    logic          wrap_n;
    logic          update_n;
    logic          ones_c;
    logic          tens_c;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_inc),
        .press (inc_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_dec),
        .press (dec_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clr),
        .press (clr_press)
    );

    // Auto-increment prescaler: counts only while run_en is high, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (run_en) begin
            if (presc == PRE_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign tick    = run_en && (presc == PRE_LAST);
    assign inc_req = inc_press | tick;
    assign dec_req = dec_press;

    // Next count: clear wins; simultaneous up and down requests cancel out.
    always_comb begin
        tens_n = tens;
        ones_n = ones;
        wrap_n = 1'b0;
        ones_c = 1'b0;
        tens_c = 1'b0;
        if (clr_press) begin
            tens_n = 4'd0;
            ones_n = 4'd0;
        end else if (inc_req && !dec_req) begin
            {ones_c, ones_n} = bcd_inc(ones);
            if (ones_c) begin
                {tens_c, tens_n} = bcd_inc(tens);
                wrap_n = tens_c;
            end
        end else if (dec_req && !inc_req) begin
            {ones_c, ones_n} = bcd_dec(ones);
            if (ones_c) begin
                {tens_c, tens_n} = bcd_dec(tens);
                wrap_n = tens_c;
            end
        end
    end

    // A clear at 00 is not a change, so it raises no update.
    assign update_n = (tens_n != tens) || (ones_n != ones);

    // Registered outputs: digits plus their one-cycle change and wrap flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens   <= 4'd0;
            ones   <= 4'd0;
            update <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            tens   <= tens_n;
            ones   <= ones_n;
            update <= update_n;
            wrap   <= wrap_n;
        end
    end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter with TICK_DIV=4, DEB_CYCLES=3.
// A cycle model keeps the score as an integer 0..99 and pushes the expected
// {wrap, tens, ones} for every change; a negedge monitor pops on each update.
module tb_bcd_score_counter;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_clr = 1'b0;
    logic       run_en = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       update;
    logic       wrap;

    bcd_score_counter #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .btn_clr (btn_clr),
        .run_en  (run_en),
        .tens    (tens),
        .ones    (ones),
        .update  (update),
        .wrap    (wrap)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         upd_seen = 0;
    int         wrap_seen = 0;

    // reference model: score as an integer, buttons as delayed level histories
    int model_val;
    int en_cnt;
    bit press_pend[3];
    bit acc[3];
    int streak[3];
    bit dly[3][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_val = 0;
        en_cnt    = 0;
        for (int b = 0; b < 3; b++) begin
            press_pend[b] = 1'b0;
            acc[b]        = 1'b0;
            streak[b]     = 0;
            dly[b].delete();
            dly[b].push_back(1'b0);
            dly[b].push_back(1'b0);
        end
    endtask

    task automatic push_expect(input bit w);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(model_val / 10);
        o = 4'(model_val % 10);
        exp_q.push_back({w, t, o});
    endtask

    task automatic model_step();
        bit raw[3];
        bit tick_now;
        bit inc_r;
        bit dec_r;
        bit lvl;
        raw[0] = btn_inc;
        raw[1] = btn_dec;
        raw[2] = btn_clr;
        // auto tick fires on every TICK_DIV-th enabled cycle
        tick_now = run_en && (((en_cnt + 1) % TICK_DIV) == 0);
        if (run_en) en_cnt++;
        // apply presses accepted last cycle plus this cycle's tick
        if (press_pend[2]) begin
            if (model_val != 0) begin
                model_val = 0;
                push_expect(1'b0);
            end
        end else begin
            inc_r = press_pend[0] || tick_now;
            dec_r = press_pend[1];
            if (inc_r && !dec_r) begin
                model_val = (model_val + 1) % 100;
                push_expect(model_val == 0);
            end else if (dec_r && !inc_r) begin
                model_val = (model_val + 99) % 100;
                push_expect(model_val == 99);
            end
        end
        // a button level is accepted after DEB_CYCLES consecutive disagreeing cycles,
        // seen two cycles late because of the input synchroniser
        for (int b = 0; b < 3; b++) begin
            press_pend[b] = 1'b0;
            dly[b].push_back(raw[b]);
            lvl = dly[b].pop_front();
            if (lvl != acc[b]) begin
                streak[b]++;
                if (streak[b] == DEB_CYCLES) begin
                    acc[b]        = lvl;
                    streak[b]     = 0;
                    press_pend[b] = lvl;
                end
            end else begin
                streak[b] = 0;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset) begin
            if (update) begin
                upd_seen++;
                if (wrap) wrap_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got %0d%0d wrap=%0d, expected no update",
                             tens, ones, wrap);
                end else begin
                    e = exp_q.pop_front();
                    check("update_wrap_tens_ones", {23'd0, wrap, tens, ones}, {23'd0, e});
                end
            end else begin
                check("wrap_without_update", {31'd0, wrap}, 32'd0);
            end
            check("digits_vs_model", 32'(int'(tens) * 10 + int'(ones)), 32'(model_val));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_inc = v;
            1: btn_dec = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press(input int b, input int hold, input int gap);
        set_btn(b, 1'b1);
        cycles(hold);
        set_btn(b, 1'b0);
        cycles(gap);
    endtask

    task automatic check_val(input string name, input int v);
        check({name, "_tens"}, {28'd0, tens}, 32'(v / 10));
        check({name, "_ones"}, {28'd0, ones}, 32'(v % 10));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int u0;
        int w0;
        int lat;
        model_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        check("reset_tens", {28'd0, tens}, 32'd0);
        check("reset_ones", {28'd0, ones}, 32'd0);
        check("reset_update", {31'd0, update}, 32'd0);
        check("reset_wrap", {31'd0, wrap}, 32'd0);

        // idle: nothing may happen
        cycles(50);
        check_val("idle", 0);
        check("idle_updates", 32'(upd_seen), 32'd0);

        // 40 auto ticks from 00
        run_en = 1'b1;
        cycles(160);
        run_en = 1'b0;
        cycles(2);
        check_val("ticks40", 40);
        check("ticks40_updates", 32'(upd_seen), 32'd40);

        // clear, then 00 -> 99 -> 98 by two decrements
        press(2, 8, 8);
        check_val("clr40", 0);
        press(1, 8, 8);
        press(1, 8, 8);
        check_val("preload98", 98);

        // two ticks: 98 -> 99 -> 00 with wrap
        w0 = wrap_seen;
        run_en = 1'b1;
        cycles(8);
        run_en = 1'b0;
        cycles(2);
        check_val("tick_wrap", 0);
        check("tick_wrap_count", 32'(wrap_seen - w0), 32'd1);

        // dec press at 00: latency and a single step
        cycles(4);
        u0  = upd_seen;
        w0  = wrap_seen;
        lat = -1;
        btn_dec = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (update) begin
                lat = i;
                break;
            end
        end
        check("dec_latency", 32'(lat), 32'(2 + DEB_CYCLES + 1));
        cycles(4);
        btn_dec = 1'b0;
        cycles(10);
        check_val("dec_from_00", 99);
        check("dec_single_step", 32'(upd_seen - u0), 32'd1);
        check("dec_wrap", 32'(wrap_seen - w0), 32'd1);

        // bouncing inc, then stable: exactly one +1 (99 -> 00)
        u0 = upd_seen;
        for (int k = 0; k < 4; k++) begin
            btn_inc = ~btn_inc;
            cycles(2);
        end
        btn_inc = 1'b1;
        cycles(10);
        btn_inc = 1'b0;
        cycles(10);
        check_val("bounce", 0);
        check("bounce_single_step", 32'(upd_seen - u0), 32'd1);

        // run to 57, then clr and inc together: clear wins
        run_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (model_val == 57) break;
        end
        run_en = 1'b0;
        cycles(2);
        check_val("reach57", 57);
        u0 = upd_seen;
        btn_clr = 1'b1;
        btn_inc = 1'b1;
        cycles(8);
        btn_clr = 1'b0;
        btn_inc = 1'b0;
        cycles(8);
        check_val("clr_beats_inc", 0);
        check("clr_beats_inc_updates", 32'(upd_seen - u0), 32'd1);

        // randomized button activity and run_en toggling
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 5) == 0) btn_dec = ~btn_dec;
            if ($urandom_range(0, 7) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 9) == 0) run_en = ~run_en;
        end
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_clr = 1'b0;
        run_en  = 1'b0;
        cycles(12);
        check("random_drain", 32'(exp_q.size()), 32'd0);

        // reset while an inc press is mid-debounce
        press(1, 8, 8);
        btn_inc = 1'b1;
        cycles(3);
        #2 reset = 1'b1;
        #1;
        check_val("async_reset", 0);
        check("async_reset_update", {31'd0, update}, 32'd0);
        check("async_reset_wrap", {31'd0, wrap}, 32'd0);
        cycles(3);
        reset = 1'b0;
        cycles(10);
        check_val("held_through_reset", 1);
        btn_inc = 1'b0;
        cycles(10);
        check_val("final", 1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
